// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchroniser feeding an oversampled
// start/data/stop state machine with registered done and framing-error pulses.
module uart_rx #(
   parameter int DATA_BITS = 8,
   parameter int SAMPLES   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_done,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int SW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
   localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [SW-1:0] S_MID  = SW'(SAMPLES / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(SAMPLES - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t               state_r;
   logic [SW-1:0]        s_cnt_r;
   logic [NW-1:0]        n_cnt_r;
   logic [DATA_BITS-1:0] shift_r;
   logic                 sync1_r;
   logic                 sync2_r;
   logic                 rx_s;
   logic [DATA_BITS-1:0] rx_data_r;
   logic                 rx_done_r;
   logic                 frame_err_r;
   logic                 busy_r;

   // New bit enters at the MSB so that after DATA_BITS shifts the first
   // received bit sits in bit 0.
   function automatic logic [DATA_BITS-1:0] shift_in(
      input logic [DATA_BITS-1:0] cur,
      input logic                 b
   );
      logic [DATA_BITS-1:0] nxt;
      nxt                = cur >> 1;
      nxt[DATA_BITS-1]   = b;
      return nxt;
   endfunction

   assign rx_s      = sync2_r;
   assign rx_data   = rx_data_r;
   assign rx_done   = rx_done_r;
   assign frame_err = frame_err_r;
   assign busy      = busy_r;

   // Two-flop synchroniser for the asynchronous serial line, idling high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= rx;
         sync2_r <= sync1_r;
      end
   end

   // Frame state machine; busy is updated with every state change so it
   // always mirrors state_r != IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         s_cnt_r     <= '0;
         n_cnt_r     <= '0;
         shift_r     <= '0;
         rx_data_r   <= '0;
         rx_done_r   <= 1'b0;
         frame_err_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         rx_done_r   <= 1'b0;
         frame_err_r <= 1'b0;
         case (state_r)
            IDLE: begin
               // Start edge is accepted on any clk, not just tick cycles.
               if (!rx_s) begin
                  state_r <= START;
                  s_cnt_r <= '0;
                  busy_r  <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  if (s_cnt_r == S_MID) begin
                     if (!rx_s) begin
                        state_r <= DATA;
                        s_cnt_r <= '0;
                        n_cnt_r <= '0;
                     end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                     end
                  end else begin
                     s_cnt_r <= s_cnt_r + SW'(1);
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (s_cnt_r == S_LAST) begin
                     shift_r <= shift_in(shift_r, rx_s);
                     s_cnt_r <= '0;
                     if (n_cnt_r == N_LAST) begin
                        state_r <= STOP;
                     end else begin
                        n_cnt_r <= n_cnt_r + NW'(1);
                     end
                  end else begin
                     s_cnt_r <= s_cnt_r + SW'(1);
                  end
               end
            end
            STOP: begin
               // Leaving at mid-stop-bit lets a back-to-back start edge be seen.
               if (tick) begin
                  if (s_cnt_r == S_LAST) begin
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                     s_cnt_r <= '0;
                     if (rx_s) begin
                        rx_data_r <= shift_r;
                        rx_done_r <= 1'b1;
                     end else begin
                        frame_err_r <= 1'b1;
                     end
                  end else begin
                     s_cnt_r <= s_cnt_r + SW'(1);
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               s_cnt_r <= '0;
               n_cnt_r <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: tick every 4 clk (64 clk per bit), expected
// bytes queued as frames are sent and compared against captured rx_done data.
module tb_uart_rx;

   logic       clk;
   logic       reset;
   logic       tick;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;
   logic       busy;

   logic [1:0] tick_cnt = 2'd0;

   int n_pass  = 0;
   int n_total = 0;

   // Monitor-owned capture state.
   int         done_cnt = 0;
   int         err_cnt  = 0;
   int         both_cnt = 0;
   logic [7:0] got_data [0:31];
   logic       got_busy [0:31];

   // Task-owned scoreboard state.
   logic [7:0] exp_q [$];
   int         rd_idx = 0;

   uart_rx #(.DATA_BITS(8), .SAMPLES(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial tick = 1'b0;
   always @(posedge clk) begin
      tick_cnt <= tick_cnt + 2'd1;
      tick     <= (tick_cnt == 2'd2);
   end

   always @(negedge clk) begin
      if (rx_done) begin
         if (done_cnt < 32) begin
            got_data[done_cnt] = rx_data;
            got_busy[done_cnt] = busy;
         end
         done_cnt = done_cnt + 1;
      end
      if (frame_err) err_cnt = err_cnt + 1;
      if (rx_done && frame_err) both_cnt = both_cnt + 1;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_len);
      rx = 1'b0;
      cyc(64);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         cyc(64);
      end
      rx = stop_val;
      cyc(stop_len);
      rx = 1'b1;
   endtask

   task automatic test_reset();
      int bad;
      reset = 1'b0;
      rx    = 1'b1;
      cyc(3);
      n_total++;
      if ({rx_data, rx_done, frame_err, busy} !== 11'd0) begin
         $display("FAIL reset_hold: got %h expected 000", {rx_data, rx_done, frame_err, busy});
      end else n_pass++;
      reset = 1'b1;
      bad   = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if ({rx_data, rx_done, frame_err, busy} !== 11'd0) bad++;
      end
      #1;
      n_total++;
      if (bad !== 0) $display("FAIL reset_idle: got %0d nonzero cycles expected 0", bad);
      else n_pass++;
   endtask

   task automatic test_single();
      int d0, e0;
      logic [7:0] exp;
      d0 = done_cnt;
      e0 = err_cnt;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 64);
      cyc(64);
      n_total++;
      if (done_cnt - d0 !== 1) $display("FAIL a5_done_count: got %0d expected 1", done_cnt - d0);
      else n_pass++;
      n_total++;
      if (err_cnt !== e0) $display("FAIL a5_frame_err: got %0d expected 0", err_cnt - e0);
      else n_pass++;
      while (rd_idx < done_cnt && exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         n_total++;
         if (got_data[rd_idx] !== exp) $display("FAIL a5_data: got %h expected %h", got_data[rd_idx], exp);
         else n_pass++;
         n_total++;
         if (got_busy[rd_idx] !== 1'b0) $display("FAIL a5_busy_at_done: got %b expected 0", got_busy[rd_idx]);
         else n_pass++;
         rd_idx++;
      end
   endtask

   task automatic test_frame_err();
      int d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      send_frame(8'h3C, 1'b0, 44);
      cyc(200);
      n_total++;
      if (err_cnt - e0 !== 1) $display("FAIL ferr_count: got %0d expected 1", err_cnt - e0);
      else n_pass++;
      n_total++;
      if (done_cnt !== d0) $display("FAIL ferr_no_done: got %0d expected 0", done_cnt - d0);
      else n_pass++;
      n_total++;
      if (rx_data !== 8'hA5) $display("FAIL ferr_data_held: got %h expected a5", rx_data);
      else n_pass++;
   endtask

   task automatic test_glitch();
      int d0, e0;
      logic saw_busy;
      d0 = done_cnt;
      e0 = err_cnt;
      saw_busy = 1'b0;
      rx = 1'b0;
      cyc(20);
      rx = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy) saw_busy = 1'b1;
      end
      cyc(40);
      n_total++;
      if (saw_busy !== 1'b1) $display("FAIL glitch_busy_rise: got %b expected 1", saw_busy);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL glitch_busy_fall: got %b expected 0", busy);
      else n_pass++;
      n_total++;
      if ((done_cnt - d0) + (err_cnt - e0) !== 0)
         $display("FAIL glitch_no_pulse: got %0d pulses expected 0", (done_cnt - d0) + (err_cnt - e0));
      else n_pass++;
      n_total++;
      if (rx_data !== 8'hA5) $display("FAIL glitch_data_held: got %h expected a5", rx_data);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int d0, e0;
      logic [7:0] exp;
      d0 = done_cnt;
      e0 = err_cnt;
      exp_q.push_back(8'h00);
      send_frame(8'h00, 1'b1, 64);
      exp_q.push_back(8'hFF);
      send_frame(8'hFF, 1'b1, 64);
      cyc(64);
      n_total++;
      if (done_cnt - d0 !== 2) $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0);
      else n_pass++;
      n_total++;
      if (err_cnt !== e0) $display("FAIL b2b_frame_err: got %0d expected 0", err_cnt - e0);
      else n_pass++;
      while (rd_idx < done_cnt && exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         n_total++;
         if (got_data[rd_idx] !== exp) $display("FAIL b2b_data: got %h expected %h", got_data[rd_idx], exp);
         else n_pass++;
         rd_idx++;
      end
   endtask

   task automatic test_mid_reset();
      int d0, e0;
      logic [7:0] pat;
      logic [7:0] exp;
      d0  = done_cnt;
      e0  = err_cnt;
      pat = 8'h55;
      rx  = 1'b0;
      cyc(64);
      for (int i = 0; i < 4; i++) begin
         rx = pat[i];
         cyc(64);
      end
      reset = 1'b0;
      rx    = 1'b1;
      #1;
      n_total++;
      if ({rx_data, rx_done, frame_err, busy} !== 11'd0)
         $display("FAIL midrst_outputs: got %h expected 000", {rx_data, rx_done, frame_err, busy});
      else n_pass++;
      cyc(3);
      reset = 1'b1;
      cyc(200);
      n_total++;
      if ((done_cnt - d0) + (err_cnt - e0) !== 0)
         $display("FAIL midrst_no_pulse: got %0d pulses expected 0", (done_cnt - d0) + (err_cnt - e0));
      else n_pass++;
      n_total++;
      if (rx_data !== 8'h00) $display("FAIL midrst_data_zero: got %h expected 00", rx_data);
      else n_pass++;
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, 64);
      cyc(64);
      n_total++;
      if (done_cnt - d0 !== 1) $display("FAIL midrst_81_count: got %0d expected 1", done_cnt - d0);
      else n_pass++;
      while (rd_idx < done_cnt && exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         n_total++;
         if (got_data[rd_idx] !== exp) $display("FAIL midrst_81_data: got %h expected %h", got_data[rd_idx], exp);
         else n_pass++;
         rd_idx++;
      end
   endtask

   initial begin
      reset = 1'b0;
      rx    = 1'b1;
      test_reset();
      test_single();
      test_frame_err();
      test_glitch();
      test_back_to_back();
      test_mid_reset();
      n_total++;
      if (both_cnt !== 0) $display("FAIL pulse_overlap: got %0d expected 0", both_cnt);
      else n_pass++;
      n_total++;
      if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
